// File: rtl/imem_resp_pkg.sv
// Shared definitions for the instruction-memory responder and its fetch initiator.
package imem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/imem_resp_array.sv
// Word storage: one synchronous write port, one combinational read port, never reset.
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Combinational read sees the pre-edge contents, so a same-cycle write returns old data.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_resp.sv
// Fixed-latency instruction fetch responder: decode, latch at accept, respond LATENCY cycles later.
// Handshake: a request is accepted on any rising edge where io_reqValid=1 and the FSM is IDLE;
// there is no ready, io_reqValid is ignored while busy, and io_respValid is a one-cycle pulse.
module imem_resp
  import imem_resp_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = IMEM_BASE_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_reqValid,
  input  logic [31:0]              io_addr,
  output logic                     io_respValid,
  output logic [31:0]              io_rdata,
  output logic                     io_err,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_data,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  imem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   data_q;
  logic          err_q;
  logic          accept;

  logic [31:0]   word_idx;
  logic [31:0]   rd_data;
  logic          dec_err;

  // Wrap-around subtraction makes addresses below BASE land far out of range.
  assign word_idx = (io_addr - BASE) >> 2;
  assign dec_err  = (io_addr[1:0] != 2'b00) || (word_idx >= 32'(DEPTH));

  imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (word_idx[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_reqValid) begin
          accept  = 1'b1;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT:    if (cnt_q == CW'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q  <= CW'(LATENCY - 1);
        data_q <= dec_err ? 32'h0 : rd_data;
        err_q  <= dec_err;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Outputs decode straight from the state register so reset clears them without a clock.
  assign io_respValid = (state_q == RESP);
  assign io_rdata     = (state_q == RESP) ? data_q : 32'h0;
  assign io_err       = (state_q == RESP) ? err_q  : 1'b0;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: four instances cover LATENCY 1..4 with shared preload and reset.
module tb_imem_resp;
  import imem_resp_pkg::*;

  localparam int          DEPTH = 16;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] BASE  = IMEM_BASE_DEFAULT;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;

  logic        req1 = 0, req2 = 0, req3 = 0, req4 = 0;
  logic [31:0] addr1 = BASE, addr2 = BASE, addr3 = BASE, addr4 = BASE;
  logic        rv1, rv2, rv3, rv4;
  logic [31:0] rd1, rd2, rd3, rd4;
  logic        er1, er2, er3, er4;
  logic        bz1, bz2, bz3, bz4;
  logic [1:0]  st1, st2, st3, st4;

  imem_resp #(.DEPTH(DEPTH), .LATENCY(1), .BASE(BASE)) u_l1 (
    .clock(clock), .reset(reset), .io_reqValid(req1), .io_addr(addr1),
    .io_respValid(rv1), .io_rdata(rd1), .io_err(er1), .busy(bz1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(st1));
  imem_resp #(.DEPTH(DEPTH), .LATENCY(2), .BASE(BASE)) u_l2 (
    .clock(clock), .reset(reset), .io_reqValid(req2), .io_addr(addr2),
    .io_respValid(rv2), .io_rdata(rd2), .io_err(er2), .busy(bz2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(st2));
  imem_resp #(.DEPTH(DEPTH), .LATENCY(3), .BASE(BASE)) u_l3 (
    .clock(clock), .reset(reset), .io_reqValid(req3), .io_addr(addr3),
    .io_respValid(rv3), .io_rdata(rd3), .io_err(er3), .busy(bz3),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(st3));
  imem_resp #(.DEPTH(DEPTH), .LATENCY(4), .BASE(BASE)) u_l4 (
    .clock(clock), .reset(reset), .io_reqValid(req4), .io_addr(addr4),
    .io_respValid(rv4), .io_rdata(rd4), .io_err(er4), .busy(bz4),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(st4));

  // scoreboard counters
  int checks   = 0;
  int failures = 0;
  int pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs set afterwards are sampled at the following edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // LATENCY=2 error read: accept, wait, check the error response.
  task automatic err_read2(input string tag, input logic [31:0] a);
    req2 = 1'b1; addr2 = a;
    step();
    req2 = 1'b0;
    step();
    chk({tag, "_valid"}, 32'(rv2), 32'd1);
    chk({tag, "_err"},   32'(er2), 32'd1);
    chk({tag, "_rdata"}, rd2, 32'h0);
    step();
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", 32'(rv2), 32'd0);
    chk("rst_rdata", rd2, 32'h0);
    chk("rst_err",   32'(er2), 32'd0);
    chk("rst_busy",  32'(bz2), 32'd0);
    chk("rst_state", 32'(st2), 32'(IDLE));
    step();
    reset = 1'b0;
    step();

    preload(4'd0,  32'hCAFE_0000);
    preload(4'd1,  32'hCAFE_0004);
    preload(4'd2,  32'h1111_1111);
    preload(4'd3,  32'hDEAD_BEEF);
    preload(4'd15, 32'h5A5A_0F0F);

    // LATENCY=2 basic read: response only in accept+2
    req2 = 1'b1; addr2 = BASE + 32'd12;
    step();
    req2 = 1'b0;
    chk("l2_n1_valid", 32'(rv2), 32'd0);
    chk("l2_n1_busy",  32'(bz2), 32'd1);
    chk("l2_n1_state", 32'(st2), 32'(WAIT));
    step();
    chk("l2_n2_valid", 32'(rv2), 32'd1);
    chk("l2_n2_rdata", rd2, 32'hDEAD_BEEF);
    chk("l2_n2_err",   32'(er2), 32'd0);
    step();
    chk("l2_n3_valid", 32'(rv2), 32'd0);
    chk("l2_n3_rdata", rd2, 32'h0);
    chk("l2_n3_busy",  32'(bz2), 32'd0);

    // LATENCY=1 with a held request: responses at N+1 and N+3
    req1 = 1'b1; addr1 = BASE;
    step();
    addr1 = BASE + 32'd4;
    chk("l1_n1_valid", 32'(rv1), 32'd1);
    chk("l1_n1_rdata", rd1, 32'hCAFE_0000);
    step();
    chk("l1_gap_valid", 32'(rv1), 32'd0);
    chk("l1_gap_busy",  32'(bz1), 32'd0);
    step();
    req1 = 1'b0;
    chk("l1_n3_valid", 32'(rv1), 32'd1);
    chk("l1_n3_rdata", rd1, 32'hCAFE_0004);
    step();
    chk("l1_n4_valid", 32'(rv1), 32'd0);

    // address errors and the last valid word
    err_read2("misalign", BASE + 32'd2);
    err_read2("past_end", BASE + 32'(4 * DEPTH));
    err_read2("below_base", BASE - 32'd4);
    req2 = 1'b1; addr2 = BASE + 32'(4 * (DEPTH - 1));
    step();
    req2 = 1'b0;
    step();
    chk("last_word_err",   32'(er2), 32'd0);
    chk("last_word_rdata", rd2, 32'h5A5A_0F0F);
    step();

    // write in the accept cycle and during WAIT leaves the pending data alone
    req2 = 1'b1; addr2 = BASE + 32'd8;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h2222_2222;
    step();
    req2 = 1'b0;
    step();
    wr_en = 1'b0;
    chk("rbw_valid", 32'(rv2), 32'd1);
    chk("rbw_rdata", rd2, 32'h1111_1111);
    step();
    req2 = 1'b1; addr2 = BASE + 32'd8;
    step();
    req2 = 1'b0;
    step();
    chk("rbw_later_rdata", rd2, 32'h2222_2222);
    step();

    // LATENCY=4: reset after accept discards the response
    req4 = 1'b1; addr4 = BASE + 32'd12;
    step();
    req4 = 1'b0;
    reset = 1'b1;
    #1;
    chk("l4_rst_busy",  32'(bz4), 32'd0);
    chk("l4_rst_state", 32'(st4), 32'(IDLE));
    step();
    step();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rv4) pulses++;
      if (bz4) pulses++;
    end
    chk("l4_no_pulse_or_busy", 32'(pulses), 32'd0);
    req4 = 1'b1; addr4 = BASE + 32'd12;
    step();
    req4 = 1'b0;
    step();
    step();
    chk("l4_n3_valid", 32'(rv4), 32'd0);
    step();
    chk("l4_n4_valid", 32'(rv4), 32'd1);
    chk("l4_mem_kept", rd4, 32'hDEAD_BEEF);
    step();

    // LATENCY=3: toggling request while busy yields exactly one response
    req3 = 1'b1; addr3 = BASE + 32'd4;
    pulses = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      req3 = (c == 2) ? 1'b1 : 1'b0;
      chk($sformatf("l3_c%0d_valid", c), 32'(rv3), (c == 3) ? 32'd1 : 32'd0);
      if (rv3) begin
        pulses++;
        chk("l3_rdata", rd3, 32'hCAFE_0004);
      end
      if (c >= 4) chk($sformatf("l3_c%0d_state", c), 32'(st3), 32'(IDLE));
    end
    chk("l3_one_response", 32'(pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter DEPTH, default 1024, meaning the number of 32-bit memory words (power of two, at least 2).
REQ-002 Parameter LATENCY, default 2, meaning the number of cycles from request accept to response (at least 1).
REQ-003 Parameter BASE, default 32'h8000_0000, meaning the byte address of word 0.
REQ-004 Port clock, input, 1 bit: clock, rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port io_reqValid, input, 1 bit: fetch request from the initiator.
REQ-007 Port io_addr, input, 32 bits: fetch byte address, sampled on accept.
REQ-008 Port io_respValid, output, 1 bit: response strobe, a single-cycle pulse.
REQ-009 Port io_rdata, output, 32 bits: fetched word, valid only while io_respValid is high.
REQ-010 Port io_err, output, 1 bit: access error, valid only while io_respValid is high.
REQ-011 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 Port wr_en, input, 1 bit: preload write strobe.
REQ-013 Port wr_addr, input, $clog2(DEPTH) bits: word index for the preload write.
REQ-014 Port wr_data, input, 32 bits: preload write data.

Function
REQ-015 The FSM SHALL have three states, IDLE, WAIT and RESP, held in a registered current-state plus a combinational next-state.
REQ-016 In IDLE with io_reqValid=1, the block SHALL accept the request:
- latch the read word and the error flag;
- load the counter with LATENCY-1;
- go to RESP if LATENCY==1, otherwise to WAIT.
REQ-017 In IDLE with io_reqValid=0, the block SHALL remain in IDLE.
REQ-018 In WAIT, the counter SHALL decrement each cycle; on the cycle the counter equals 1, next state SHALL be RESP.
REQ-019 Accepting in cycle N SHALL produce io_respValid=1 in exactly cycle N+LATENCY.
REQ-020 In RESP, io_respValid SHALL be 1 for exactly one cycle and next state SHALL be IDLE.
REQ-021 io_reqValid SHALL be ignored in WAIT and RESP; a held request is re-accepted in the first IDLE cycle.
REQ-022 Address decode: word index = (io_addr - BASE) >> 2, using 32-bit wrap-around subtraction.
REQ-023 An error SHALL be flagged, with latched rdata 0 and io_err=1 at response, when either condition holds:
- io_addr[1:0] != 0;
- the word index is >= DEPTH (this includes io_addr < BASE via wrap).
REQ-024 Outside RESP: io_respValid=0, io_err=0, io_rdata=0.
REQ-025 A wr_en write SHALL update mem[wr_addr] at the clock edge, in any state.
REQ-026 A write to the same word in the accept cycle: the response SHALL return the old data (read before write).
REQ-027 A write during WAIT to the pending word SHALL NOT alter the pending response data.
REQ-028 The counter width SHALL be $clog2(LATENCY+1) bits, with no wrap-around in legal operation.

Reset
REQ-029 Reset assertion SHALL immediately force:
- state IDLE;
- counter 0;
- latched data 0 and latched error 0;
- io_respValid=0, io_err=0, io_rdata=0, busy=0.
REQ-030 Reset during WAIT or RESP SHALL discard the pending response; no io_respValid pulse SHALL follow release.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 The state enum type and the BASE default constant SHALL live in a shared package shared with the fetch initiator.
REQ-033 The storage array SHALL be a sub-module imem_array (one synchronous write port, one combinational read port).
REQ-034 The FSM, counter, decode and response latch SHALL live in imem_resp.

Verification
REQ-035 Preload mem[3]=32'hDEAD_BEEF with LATENCY=2; pulse io_reqValid with io_addr=BASE+12 in cycle 10 -> io_respValid=1, io_rdata=32'hDEAD_BEEF, io_err=0 in cycle 12 only.
REQ-036 LATENCY=1 with io_reqValid held high, addresses BASE+0 then BASE+4 -> responses in cycles N+1 and N+3, with one idle gap cycle between them.
REQ-037 io_addr=BASE+2, then io_addr=BASE+4*DEPTH, then io_addr=BASE-4 -> each response has io_err=1 and io_rdata=0.
REQ-038 Accept io_addr=BASE+8 with mem[2]=32'h1111_1111; write wr_addr=2, wr_data=32'h2222_2222 in the accept cycle and again during WAIT -> response returns 32'h1111_1111; a later read returns 32'h2222_2222.
REQ-039 With LATENCY=4, assert reset in the cycle after accept and release it 2 cycles later -> no io_respValid pulse for 10 cycles; busy=0; preloaded memory is intact.
REQ-040 With LATENCY=3, toggle io_reqValid on every cycle during WAIT -> exactly one response, and no extra accept until the FSM returns to IDLE.
